// File: rtl/rd_return_delay_serializer_if.sv
// Read-return bus between the beat producer, the delay serializer and the return path.
//   RD/dest       : 128-bit read beat and its destination core (dest 0 = no beat)
//   full/overflow : producer stall flag and sticky dropped-beat flag
//   rdReady       : return path accepts the presented word
//   RDreturn      : presented 32-bit word
//   RDdest        : destination of the presented word (0 = no word valid)
interface rd_return_delay_serializer_if;
    logic [127:0] RD;
    logic [3:0]   dest;
    logic         full;
    logic         overflow;
    logic         rdReady;
    logic [31:0]  RDreturn;
    logic [3:0]   RDdest;

    // Producer / return-path side
    modport master (
        output RD, dest, rdReady,
        input  full, overflow, RDreturn, RDdest
    );

    // Serializer side
    modport slave (
        input  RD, dest, rdReady,
        output full, overflow, RDreturn, RDdest
    );
endinterface

// File: rtl/rd_return_delay_serializer.sv
// Holds 128-bit read beats for a programmable minimum latency, then emits each
// beat as four 32-bit words (low word first) under a ready handshake.
//   clock : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : slave side of rd_return_delay_serializer_if (beat in, words out,
//           full/overflow status)
module rd_return_delay_serializer #(
    parameter int unsigned DELAY_CYCLES = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_BITS     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    rd_return_delay_serializer_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LOAD  = (DELAY_CYCLES == 0) ? 1 : DELAY_CYCLES;
    localparam logic [CNT_BITS-1:0] LOAD_VAL = CNT_BITS'(LOAD);
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   dest;
    } beat_t;

    typedef enum logic {IDLE, SEND} state_t;

    beat_t               mem   [DEPTH];
    logic [CNT_BITS-1:0] cnt   [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [PTR_W-1:0]    nextPtr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    countNext;
    logic [1:0]          wordIdx;
    logic [1:0]          idxNext;
    state_t              state;

    logic push;
    logic pop;
    logic headRipe;
    logic nextRipe;
    logic beatIn;

    // Fullness is judged on the pre-pop count, so a beat arriving while full is dropped
    assign beatIn   = (bus.dest != 4'd0);
    assign push     = beatIn && (count != FULL_CNT);
    assign pop      = (state == SEND) && bus.rdReady && (wordIdx == 2'd3);
    assign nextPtr  = rdPtr + PTR_W'(1);
    assign idxNext  = wordIdx + 2'd1;
    assign headRipe = valid[rdPtr]   && (cnt[rdPtr]   == '0);
    assign nextRipe = valid[nextPtr] && (cnt[nextPtr] == '0);

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    // Beat storage (payload needs no reset; validity is tracked separately)
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= {bus.RD, bus.dest};
        end
    end

    // FIFO bookkeeping, per-entry countdowns and status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            bus.full     <= 1'b0;
            bus.overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // All waiting entries ripen in parallel, not just the head
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push && (wrPtr == PTR_W'(i))) begin
                    cnt[i] <= LOAD_VAL;
                end else if (valid[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_BITS'(1);
                end
            end
            if (pop) begin
                valid[rdPtr] <= 1'b0;
            end
            if (push) begin
                valid[wrPtr] <= 1'b1;
                wrPtr        <= wrPtr + PTR_W'(1);
            end
            count    <= countNext;
            bus.full <= (countNext == FULL_CNT);
            if (beatIn && (count == FULL_CNT)) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    // Serializer FSM with registered word/destination outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rdPtr        <= '0;
            wordIdx      <= 2'd0;
            bus.RDreturn <= 32'd0;
            bus.RDdest   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (headRipe) begin
                        state        <= SEND;
                        wordIdx      <= 2'd0;
                        bus.RDreturn <= mem[rdPtr].data[31:0];
                        bus.RDdest   <= mem[rdPtr].dest;
                    end
                end
                SEND: begin
                    if (bus.rdReady) begin
                        if (wordIdx != 2'd3) begin
                            wordIdx      <= idxNext;
                            bus.RDreturn <= mem[rdPtr].data[{idxNext, 5'd0} +: 32];
                        end else begin
                            rdPtr   <= nextPtr;
                            wordIdx <= 2'd0;
                            // Chain straight into the next ripe beat without a bubble
                            if (nextRipe) begin
                                bus.RDreturn <= mem[nextPtr].data[31:0];
                                bus.RDdest   <= mem[nextPtr].dest;
                            end else begin
                                state        <= IDLE;
                                bus.RDreturn <= 32'd0;
                                bus.RDdest   <= 4'd0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rd_return_delay_serializer.sv
// Scoreboard bench for rd_return_delay_serializer (DELAY_CYCLES=8, DEPTH=4).
module tb_rd_return_delay_serializer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    rd_return_delay_serializer_if bus ();

    rd_return_delay_serializer #(
        .DELAY_CYCLES (8),
        .DEPTH        (4),
        .CNT_BITS     (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    exp_t monExp;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pushBeat(input logic [3:0] d, input logic [127:0] data);
        for (int w = 0; w < 4; w++) begin
            sb.push_back({d, data[32*w +: 32]});
        end
    endtask

    task automatic waitDrained(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic waitWord(input string name, input int budget);
        int n;
        n = 0;
        while (bus.RDdest == 4'd0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
    endtask

    // One beat into an idle, empty FIFO with rdReady=1; checks exact latency per edge
    task automatic runSingle(input logic [3:0] d, input logic [127:0] data);
        logic [127:0] tmp;
        tmp = data;
        pushBeat(d, data);
        bus.RD   = data;
        bus.dest = d;
        tick();
        bus.dest = 4'd0;
        bus.RD   = '0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e <= 8 || e == 13) begin
                check("latency_idle_dest", 64'(bus.RDdest), 64'd0);
            end else begin
                check("latency_word_dest", 64'(bus.RDdest), 64'(d));
                check("latency_word_data", 64'(bus.RDreturn), 64'(tmp[32*(e-9) +: 32]));
            end
        end
    endtask

    // Monitor: every word accepted by the return path must match the scoreboard head
    always @(negedge clock) begin
        if (reset && bus.RDdest != 4'd0 && bus.rdReady) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h/%0h required=none", bus.RDdest, bus.RDreturn);
            end else begin
                monExp = sb.pop_front();
                check("sb_word", {28'd0, bus.RDdest, bus.RDreturn}, {28'd0, monExp.dest, monExp.word});
            end
        end
    end

    initial begin
        logic [127:0] beat;
        int           sent;
        int           n;

        bus.RD      = '0;
        bus.dest    = 4'd0;
        bus.rdReady = 1'b1;

        // Reset state
        #1 reset = 1'b0;
        #1;
        check("reset_rddest",   64'(bus.RDdest),   64'd0);
        check("reset_rdreturn", 64'(bus.RDreturn), 64'd0);
        check("reset_full",     64'(bus.full),     64'd0);
        check("reset_overflow", 64'(bus.overflow), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single beat with exact latency
        runSingle(4'd3, 128'h44444444_33333333_22222222_11111111);
        waitDrained("single_drained", 20);

        // Back-to-back beats: eight contiguous words
        pushBeat(4'd2, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        pushBeat(4'd2, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
        bus.RD   = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        bus.dest = 4'd2;
        tick();
        bus.RD   = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        tick();
        bus.dest = 4'd0;
        waitWord("b2b_start", 30);
        for (int k = 0; k < 8; k++) begin
            check("b2b_contiguous", 64'(bus.RDdest), 64'd2);
            tick();
        end
        check("b2b_end_idle", 64'(bus.RDdest), 64'd0);
        waitDrained("b2b_drained", 20);

        // Backpressure on the second word
        pushBeat(4'd5, 128'h44444444_33333333_22222222_11111111);
        bus.RD   = 128'h44444444_33333333_22222222_11111111;
        bus.dest = 4'd5;
        tick();
        bus.dest = 4'd0;
        waitWord("bp_start", 30);
        tick();
        bus.rdReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_data", 64'(bus.RDreturn), 64'h22222222);
            check("bp_hold_dest", 64'(bus.RDdest),   64'd5);
            tick();
        end
        bus.rdReady = 1'b1;
        tick();
        check("bp_resume_word", 64'(bus.RDreturn), 64'h33333333);
        waitDrained("bp_drained", 20);

        // Wrap-around stream with rdReady toggling and a full-respecting producer
        sent = 0;
        n    = 0;
        while ((sent < 10 || sb.size() != 0) && n < 600) begin
            bus.rdReady = ~bus.rdReady;
            if (sent < 10 && !bus.full) begin
                for (int w = 0; w < 4; w++) begin
                    beat[32*w +: 32] = 32'hC000_0000 + 32'(sent << 8) + 32'(w);
                end
                pushBeat(4'(sent % 15 + 1), beat);
                bus.RD   = beat;
                bus.dest = 4'(sent % 15 + 1);
                sent++;
            end else begin
                bus.dest = 4'd0;
            end
            tick();
            n++;
        end
        bus.dest    = 4'd0;
        bus.rdReady = 1'b1;
        check("wrap_all_sent", 64'(sent), 64'd10);
        check("wrap_drained",  64'(sb.size()), 64'd0);
        check("wrap_no_overflow", 64'(bus.overflow), 64'd0);

        // Full and overflow with a stalled return path
        bus.rdReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            for (int w = 0; w < 4; w++) begin
                beat[32*w +: 32] = 32'hD000_0000 + 32'(i << 4) + 32'(w);
            end
            if (i <= 4) begin
                pushBeat(4'(i), beat);
            end
            bus.RD   = beat;
            bus.dest = 4'(i);
            tick();
            check("fill_full",     64'(bus.full),     64'(i >= 4));
            check("fill_overflow", 64'(bus.overflow), 64'(i >= 5));
        end
        bus.dest = 4'd0;
        for (int k = 0; k < 12; k++) begin
            tick();
        end
        check("stall_head_dest", 64'(bus.RDdest),   64'd1);
        check("stall_head_word", 64'(bus.RDreturn), 64'hD000_0010);
        bus.rdReady = 1'b1;
        waitDrained("full_drained", 40);
        check("overflow_sticky", 64'(bus.overflow), 64'd1);
        check("full_cleared",    64'(bus.full),     64'd0);

        // Asynchronous reset while word1 is presented
        sb.push_back({4'd6, 32'h6000_0000});
        bus.RD   = 128'h6000_0003_6000_0002_6000_0001_6000_0000;
        bus.dest = 4'd6;
        tick();
        bus.dest = 4'd0;
        waitWord("rst_start", 30);
        tick();
        check("rst_pre_word1",    64'(bus.RDreturn), 64'h6000_0001);
        check("rst_pre_overflow", 64'(bus.overflow), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_async_rddest",   64'(bus.RDdest),   64'd0);
        check("rst_async_rdreturn", 64'(bus.RDreturn), 64'd0);
        check("rst_async_full",     64'(bus.full),     64'd0);
        check("rst_async_overflow", 64'(bus.overflow), 64'd0);
        sb.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        tick();
        runSingle(4'd7, 128'h77770003_77770002_77770001_77770000);
        waitDrained("rst_after_drained", 20);

        tick();
        tick();
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
